// File: rtl/adder_sched.sv
// Round-robin scheduler that lets N_REQ requesters share one streaming adder.
// The granted requester's index rides through an in-flight tag FIFO so that each
// result coming back from the adder is steered to the requester that issued it.
// A flush request drains all outstanding work and then pulses flush_done.
// Optional feature: define ADDER_SCHED_STATS_EN to build the issue/return counters.
module adder_sched #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 16,
    parameter int TAG_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_a,
    input  logic [N_REQ*DATA_W-1:0]   req_b,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      add_a_valid,
    output logic                      add_b_valid,
    output logic [DATA_W-1:0]         add_a_data,
    output logic [DATA_W-1:0]         add_b_data,
    input  logic                      add_a_full,
    input  logic                      add_b_full,
    input  logic                      add_out_valid,
    input  logic [DATA_W:0]           add_out_data,
    output logic [N_REQ-1:0]          res_valid,
    output logic [DATA_W:0]           res_data,
    input  logic                      flush,
    output logic                      flush_done,
    output logic                      err_orphan,
    output logic [31:0]               stat_issued,
    output logic [31:0]               stat_returned
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rrPtr_q;
    logic [IDX_W-1:0]   rrNext;
    logic [IDX_W-1:0]   grantIdx;
    logic               grantFound;
    logic [IDX_W-1:0]   tagMem_q [TAG_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]   tagCount_q;
    logic               tagFull, tagEmpty;
    logic               issue, pop, orphan;
    logic [IDX_W-1:0]   popTag;
    logic [N_REQ-1:0]   resValid_q, resValid_d;
    logic [DATA_W:0]    resData_q, resData_d;
    logic               errOrphan_q;

    // Round-robin search: first valid requester at or after the pointer, wrapping around.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grantFound && req_valid[(int'(rrPtr_q) + k) % N_REQ]) begin
                grantFound = 1'b1;
                grantIdx   = IDX_W'((int'(rrPtr_q) + k) % N_REQ);
            end
        end
    end

    // A full tag FIFO still accepts a push when a result pops an entry in the same cycle.
    assign tagEmpty = (tagCount_q == '0);
    assign pop      = add_out_valid && !tagEmpty;
    assign orphan   = add_out_valid && tagEmpty;
    assign tagFull  = (tagCount_q == CNT_W'(TAG_DEPTH)) && !pop;
    assign issue    = !rst && (state_q == RUN) && grantFound &&
                      !add_a_full && !add_b_full && !tagFull;
    assign rrNext   = (int'(grantIdx) == N_REQ - 1) ? '0 : grantIdx + 1'b1;
    assign popTag   = tagMem_q[rdPtr_q];

    assign req_ready   = issue ? (N_REQ'(1) << grantIdx) : '0;
    assign add_a_valid = issue;
    assign add_b_valid = issue;
    assign add_a_data  = req_a[grantIdx*DATA_W +: DATA_W];
    assign add_b_data  = req_b[grantIdx*DATA_W +: DATA_W];

    // Tag storage holds no control state, so it is written without reset.
    always_ff @(posedge clk) begin
        if (issue) begin
            tagMem_q[wrPtr_q] <= grantIdx;
        end
    end

    // Tag FIFO pointers, occupancy and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            tagCount_q <= '0;
            rrPtr_q    <= '0;
        end else begin
            if (issue) begin
                wrPtr_q <= wrPtr_q + 1'b1;
                rrPtr_q <= rrNext;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (issue && !pop) begin
                tagCount_q <= tagCount_q + 1'b1;
            end else if (pop && !issue) begin
                tagCount_q <= tagCount_q - 1'b1;
            end
        end
    end

    // Steer each popped result to the requester whose tag it carries.
    always_comb begin
        resValid_d = '0;
        resData_d  = resData_q;
        if (pop) begin
            resValid_d[popTag] = 1'b1;
            resData_d          = add_out_data;
        end
    end

    // Registered result stream plus the sticky orphan-result flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            resValid_q  <= '0;
            resData_q   <= '0;
            errOrphan_q <= 1'b0;
        end else begin
            resValid_q <= resValid_d;
            resData_q  <= resData_d;
            if (orphan) begin
                errOrphan_q <= 1'b1;
            end
        end
    end

    assign res_valid  = resValid_q;
    assign res_data   = resData_q;
    assign err_orphan = errOrphan_q;

    // Flush sequencing: an already-empty FIFO skips DRAIN and goes straight to DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = (tagEmpty && !issue) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (tagEmpty) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign flush_done = (state_q == DONE);

`ifdef ADDER_SCHED_STATS_EN
    logic [31:0] statIssued_q, statReturned_q;

    // Free-running issue/return counters that wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            statIssued_q   <= '0;
            statReturned_q <= '0;
        end else begin
            if (issue) begin
                statIssued_q <= statIssued_q + 32'd1;
            end
            if (pop) begin
                statReturned_q <= statReturned_q + 32'd1;
            end
        end
    end

    assign stat_issued   = statIssued_q;
    assign stat_returned = statReturned_q;
`else
    assign stat_issued   = '0;
    assign stat_returned = '0;
`endif

endmodule

// File: tb/tb_adder_sched.sv
// Self-checking bench for adder_sched. The bench plays the adder itself (a queue of
// sums with a programmable latency) and predicts grants, routing and flush behaviour
// from a queue-based reference model.
module tb_adder_sched;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TD = 8;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_a, req_b;
    logic [N-1:0]      req_ready;
    logic              add_a_valid, add_b_valid;
    logic [DW-1:0]     add_a_data, add_b_data;
    logic              add_a_full, add_b_full;
    logic              add_out_valid;
    logic [DW:0]       add_out_data;
    logic [N-1:0]      res_valid;
    logic [DW:0]       res_data;
    logic              flush;
    logic              flush_done;
    logic              err_orphan;
    logic [31:0]       stat_issued, stat_returned;

    adder_sched #(.N_REQ(N), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .add_a_valid(add_a_valid), .add_b_valid(add_b_valid),
        .add_a_data(add_a_data), .add_b_data(add_b_data),
        .add_a_full(add_a_full), .add_b_full(add_b_full),
        .add_out_valid(add_out_valid), .add_out_data(add_out_data),
        .res_valid(res_valid), .res_data(res_data),
        .flush(flush), .flush_done(flush_done), .err_orphan(err_orphan),
        .stat_issued(stat_issued), .stat_returned(stat_returned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [DW:0] sum;
        int          due;
    } addEntry_t;

    addEntry_t   adderQ[$];
    int          tagQ[$];
    int          total, bad, cyc;

    logic [N-1:0]    drvValid;
    logic [N*DW-1:0] drvA, drvB;
    logic            drvFullA, drvFullB, drvFlush, drvRst, drvInject;
    int              relMode;
    int              lat;

    int              nextStart;
    int              mode;
    logic [N-1:0]    expResValid;
    logic [DW:0]     expResData;
    logic            expOrphan;
    int unsigned     stIss, stRet;

    // Count one comparison and report it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Round-robin choice: first valid index starting just after the last grant.
    function automatic int pickGrant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(nextStart + k) % N]) return (nextStart + k) % N;
        end
        return -1;
    endfunction

    // Drive one cycle of stimulus, check the combinational and registered outputs.
    task automatic applyStimulus();
        logic        aov;
        logic [DW:0] aod;
        int          occ;
        bit          popH;
        int          g;
        bit          expIssue;
        logic [N-1:0] expReady;
        int          t;
        addEntry_t   e;
        @(negedge clk);
        rst        = drvRst;
        req_valid  = drvValid;
        req_a      = drvA;
        req_b      = drvB;
        add_a_full = drvFullA;
        add_b_full = drvFullB;
        flush      = drvFlush;
        aov = 1'b0;
        aod = '0;
        if (drvInject) begin
            aov = 1'b1;
            aod = 17'h1234;
        end else if (adderQ.size() > 0 && adderQ[0].due <= cyc &&
                     (relMode == 1 || (relMode == 2 && $urandom_range(0, 3) != 0))) begin
            aov = 1'b1;
            aod = adderQ[0].sum;
            void'(adderQ.pop_front());
        end
        add_out_valid = aov;
        add_out_data  = aod;
        #1;
        if (drvRst) begin
            checkOutput("ready_in_rst", 64'(req_ready), 64'd0);
            checkOutput("avalid_in_rst", 64'(add_a_valid), 64'd0);
            checkOutput("bvalid_in_rst", 64'(add_b_valid), 64'd0);
            tagQ.delete();
            nextStart   = 0;
            mode        = 0;
            expResValid = '0;
            expResData  = '0;
            expOrphan   = 1'b0;
            stIss       = 0;
            stRet       = 0;
        end else begin
            occ      = tagQ.size();
            popH     = aov && (occ > 0);
            g        = pickGrant(drvValid);
            expIssue = (mode == 0) && (g >= 0) && !drvFullA && !drvFullB && !(occ == TD && !popH);
            expReady = '0;
            if (expIssue) expReady[g] = 1'b1;
            checkOutput("req_ready", 64'(req_ready), 64'(expReady));
            checkOutput("add_a_valid", 64'(add_a_valid), 64'(expIssue));
            checkOutput("add_b_valid", 64'(add_b_valid), 64'(expIssue));
            if (expIssue) begin
                checkOutput("add_a_data", 64'(add_a_data), 64'(drvA[g*DW +: DW]));
                checkOutput("add_b_data", 64'(add_b_data), 64'(drvB[g*DW +: DW]));
            end
            expResValid = '0;
            if (aov) begin
                if (popH) begin
                    t = tagQ.pop_front();
                    expResValid[t] = 1'b1;
                    expResData     = aod;
                    stRet++;
                end else begin
                    expOrphan = 1'b1;
                end
            end
            if (expIssue) begin
                tagQ.push_back(g);
                nextStart = (g + 1) % N;
                e.sum = {1'b0, drvA[g*DW +: DW]} + {1'b0, drvB[g*DW +: DW]};
                e.due = cyc + lat;
                adderQ.push_back(e);
                stIss++;
            end
            case (mode)
                0:       if (drvFlush) mode = (occ == 0 && !expIssue) ? 2 : 1;
                1:       if (occ == 0) mode = 2;
                default: mode = 0;
            endcase
        end
        @(posedge clk);
        #1;
        checkOutput("res_valid", 64'(res_valid), 64'(expResValid));
        checkOutput("res_data", 64'(res_data), 64'(expResData));
        checkOutput("err_orphan", 64'(err_orphan), 64'(expOrphan));
        checkOutput("flush_done", 64'(flush_done), 64'(mode == 2));
`ifdef ADDER_SCHED_STATS_EN
        checkOutput("stat_issued", 64'(stat_issued), 64'(stIss));
        checkOutput("stat_returned", 64'(stat_returned), 64'(stRet));
`else
        checkOutput("stat_issued", 64'(stat_issued), 64'd0);
        checkOutput("stat_returned", 64'(stat_returned), 64'd0);
`endif
        cyc++;
    endtask

    task automatic randOps();
        drvA = {$urandom, $urandom};
        drvB = {$urandom, $urandom};
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic idle(input int n);
        drvValid = '0;
        drvFlush = 1'b0;
        runCycles(n);
    endtask

    // Directed scenarios followed by a randomized soak.
    initial begin
        total = 0; bad = 0; cyc = 0;
        nextStart = 0; mode = 0; expResValid = '0; expResData = '0; expOrphan = 1'b0;
        stIss = 0; stRet = 0;
        drvValid = '1; drvA = '0; drvB = '0; drvFullA = 0; drvFullB = 0;
        drvFlush = 0; drvRst = 1; drvInject = 0; relMode = 1; lat = 2;

        $display("[TB] reset with all requesters valid");
        runCycles(2);
        drvRst = 0;
        idle(1);

        $display("[TB] single requester 3+5, latency 2");
        drvValid = 4'b0001;
        drvA = '0; drvB = '0;
        drvA[DW-1:0] = 16'd3;
        drvB[DW-1:0] = 16'd5;
        runCycles(1);
        idle(5);

        $display("[TB] all requesters continuously valid");
        lat = 3;
        drvValid = 4'b1111;
        for (int i = 0; i < 12; i++) begin randOps(); applyStimulus(); end
        idle(6);

        $display("[TB] adder input full back-pressure");
        drvValid = 4'b1111; drvFullA = 1;
        for (int i = 0; i < 5; i++) begin randOps(); applyStimulus(); end
        drvFullA = 0;
        runCycles(2);
        drvFullB = 1;
        runCycles(2);
        drvFullB = 0;
        idle(6);

        $display("[TB] tag FIFO fill with results held off");
        relMode = 0; lat = 1; drvValid = 4'b1111;
        for (int i = 0; i < 10; i++) begin randOps(); applyStimulus(); end
        relMode = 1;
        runCycles(1);
        relMode = 0;
        runCycles(2);
        relMode = 1;
        idle(14);

        $display("[TB] flush with three in flight");
        relMode = 0; lat = 2; drvValid = 4'b0001;
        for (int i = 0; i < 3; i++) begin randOps(); applyStimulus(); end
        drvValid = '0; drvFlush = 1;
        runCycles(1);
        drvFlush = 0; drvValid = 4'b1111;
        runCycles(3);
        relMode = 1;
        runCycles(8);
        idle(12);

        $display("[TB] flush with nothing in flight");
        drvFlush = 1;
        runCycles(1);
        idle(3);

        $display("[TB] orphan result");
        drvInject = 1;
        runCycles(1);
        drvInject = 0;
        idle(3);

        $display("[TB] reset with work outstanding");
        relMode = 0; drvValid = 4'b1111;
        for (int i = 0; i < 3; i++) begin randOps(); applyStimulus(); end
        drvValid = '0; drvRst = 1;
        runCycles(1);
        drvRst = 0;
        runCycles(2);
        relMode = 1;
        idle(8);

        $display("[TB] randomized traffic");
        relMode = 2;
        for (int i = 0; i < 400; i++) begin
            drvValid = N'($urandom);
            drvFullA = ($urandom_range(0, 7) == 0);
            drvFullB = ($urandom_range(0, 7) == 0);
            drvFlush = ($urandom_range(0, 39) == 0);
            lat      = $urandom_range(1, 4);
            randOps();
            applyStimulus();
        end
        drvFullA = 0; drvFullB = 0; relMode = 1;
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_sched.md
ADDER_SCHED -- requirements
Module: adder_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the adder (2..8).
REQ-002 Parameter DATA_W, default 16, operand width; result width RES_W = DATA_W+1.
REQ-003 Parameter TAG_DEPTH, default 8, in-flight tag FIFO depth (power of 2).
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  N_REQ  per-requester operand pair valid.
REQ-007 req_a, req_b  in  N_REQ*DATA_W each  packed operands, requester i at bits [i*DATA_W +: DATA_W].
REQ-008 req_ready  out  N_REQ  one-hot grant; pair accepted when req_valid[i] && req_ready[i].
REQ-009 add_a_valid, add_b_valid  out  1 each  adder input write enables.
REQ-010 add_a_data, add_b_data  out  DATA_W each  adder operands.
REQ-011 add_a_full, add_b_full  in  1 each  adder input FIFOs full.
REQ-012 add_out_valid  in  1;  add_out_data  in  RES_W  adder result stream.
REQ-013 res_valid  out  N_REQ  one-hot result strobe;  res_data  out  RES_W  routed result.
REQ-014 flush  in  1  drain request;  flush_done  out  1  one-cycle pulse when drained.
REQ-015 err_orphan  out  1  sticky: result arrived with no outstanding tag.
REQ-016 stat_issued, stat_returned  out  32 each  statistics counters (see Configuration).

Function
REQ-017 Issue condition: FSM in RUN, some req_valid set, !add_a_full, !add_b_full, tag FIFO not full.
REQ-018 On issue, exactly one requester granted; req_ready combinational from current state and inputs.
REQ-019 Arbitration round-robin: search starts at last-granted index+1 modulo N_REQ; after reset search starts at 0.
REQ-020 On issue, add_a_valid and add_b_valid asserted together in the same cycle with granted req_a/req_b; never one without the other.
REQ-021 On issue, granted index pushed into tag FIFO same cycle.
REQ-022 Full back-pressure: if either add_*_full or tag FIFO full, req_ready = 0, add_*_valid = 0.
REQ-023 On add_out_valid, tag FIFO popped; res_valid[tag] = 1 and res_data = add_out_data registered, one cycle latency.
REQ-024 Push and pop in same cycle: occupancy unchanged; push legal when full only if simultaneous pop occurs (full-with-pop counts as not full).
REQ-025 add_out_valid with tag FIFO empty: no res_valid, err_orphan set until rst.
REQ-026 Results returned strictly in issue order; no requester-side back-pressure on res_valid.
REQ-027 FSM states RUN, DRAIN, DONE; reset to RUN.
REQ-028 RUN -> DRAIN when flush = 1; no issue in DRAIN or DONE.
REQ-029 DRAIN -> DONE when tag FIFO empty (same cycle as flush if already empty then DONE next cycle); DONE asserts flush_done one cycle, then -> RUN.
REQ-030 Results arriving in DRAIN routed normally.

Reset
REQ-031 rst synchronous, active-high, overrides all other inputs in the cycle sampled.
REQ-032 Reset values: req_ready 0, add_a_valid/add_b_valid 0, res_valid 0, res_data 0, flush_done 0, err_orphan 0, stat_* 0, tag FIFO empty, RR pointer to index 0, FSM RUN.
REQ-033 Reset mid-operation discards outstanding tags; results arriving after reset with empty FIFO set err_orphan.

Configuration
REQ-034 Macro ADDER_SCHED_STATS_EN: when defined, stat_issued increments per issue, stat_returned per routed result, both wrap at 2^32.
REQ-035 Without ADDER_SCHED_STATS_EN, stat_issued and stat_returned tied to 0, no counter logic synthesized.

Verification
REQ-036 Single requester: req_valid=0001, a=3, b=5, adder latency 2 -> one add_a/b_valid pulse, later res_valid=0001, res_data=8.
REQ-037 All four continuously valid, full=0 -> grants 0,1,2,3,0,... one per cycle; results routed in same order.
REQ-038 add_a_full=1 for 5 cycles with req_valid=1111 -> no grants, no add_*_valid during those cycles; issue resumes next cycle after deassert.
REQ-039 Adder results held off, 8 issues -> req_ready=0 at 9th; one add_out_valid with pending request -> pop and push same cycle, issue proceeds.
REQ-040 flush with 3 in flight -> no further grants, flush_done pulses one cycle after third result; add_out_valid with empty FIFO -> err_orphan=1 until rst.
